grid_mem_arbiter: RTL



---
 rtl/grid_pkg.sv | 22 ++
 rtl/grid_mem_arbiter_if.sv | 52 +++++
 rtl/grid_addr.sv | 21 ++
 rtl/grid_mem_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants and types for the board memory arbiter
package grid_pkg;

    localparam int COLS    = 20;
    localparam int ROWS    = 15;
    localparam int CELLS   = COLS * ROWS;
    localparam int ADDR_W  = 9;
    localparam int CELL_W  = 2;
    localparam int COORD_W = 5;

    typedef enum logic [CELL_W-1:0] {
        CELL_EMPTY = 2'd0,
        CELL_P1    = 2'd1,
        CELL_P2    = 2'd2
    } cell_e;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_e;

endpackage

// File: rtl/grid_mem_arbiter_if.sv
// rtl/grid_mem_arbiter_if.sv - requester and board RAM signals of the arbiter
interface grid_mem_arbiter_if
    import grid_pkg::ADDR_W, grid_pkg::COORD_W;
#(
    parameter int CELL_W = 2
);

    logic                vga_rd_en;
    logic [COORD_W-1:0]  vga_rd_x;
    logic [COORD_W-1:0]  vga_rd_y;
    logic [CELL_W-1:0]   vga_rd_data;
    logic                vga_rd_valid;

    logic                wr_req;
    logic [COORD_W-1:0]  wr_x;
    logic [COORD_W-1:0]  wr_y;
    logic [CELL_W-1:0]   wr_data;
    logic                wr_ack;

    logic                clear_req;
    logic                clear_busy;

    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [CELL_W-1:0]   mem_wdata;
    logic [CELL_W-1:0]   mem_rdata;

    // master: game logic, renderer and RAM instance; slave: the arbiter
    modport master (
        output vga_rd_en, vga_rd_x, vga_rd_y,
        input  vga_rd_data, vga_rd_valid,
        output wr_req, wr_x, wr_y, wr_data,
        input  wr_ack,
        output clear_req,
        input  clear_busy,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  vga_rd_en, vga_rd_x, vga_rd_y,
        output vga_rd_data, vga_rd_valid,
        input  wr_req, wr_x, wr_y, wr_data,
        output wr_ack,
        input  clear_req,
        output clear_busy,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/grid_addr.sv
// rtl/grid_addr.sv - cell coordinate to board RAM address with range check
module grid_addr
    import grid_pkg::COORD_W, grid_pkg::ADDR_W;
#(
    parameter int COLS = 20,
    parameter int ROWS = 15
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_range
);

    localparam logic [COORD_W-1:0] COLS_C = COORD_W'(COLS);
    localparam logic [COORD_W-1:0] ROWS_C = COORD_W'(ROWS);
    localparam logic [ADDR_W-1:0]  COLS_A = ADDR_W'(COLS);

    assign in_range = (x < COLS_C) && (y < ROWS_C);
    assign addr     = in_range ? (ADDR_W'(y) * COLS_A + ADDR_W'(x)) : '0;

endmodule

// File: rtl/grid_mem_arbiter.sv
// rtl/grid_mem_arbiter.sv - shares the board RAM between VGA reads, cell writes and the clear sweep
module grid_mem_arbiter
    import grid_pkg::ADDR_W, grid_pkg::state_e, grid_pkg::S_CLEAR, grid_pkg::S_IDLE;
#(
    parameter int COLS         = 20,
    parameter int ROWS         = 15,
    parameter int CELL_W       = 2,
    parameter int STARVE_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    grid_mem_arbiter_if.slave bus
);

    localparam int                SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(COLS * ROWS - 1);

    state_e              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [SW-1:0]       starve_cnt;

    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic                rd_in_range;
    logic                wr_in_range;

    logic                idle;
    logic                starved;
    logic                serve_wr;
    logic                serve_rd;
    logic                go_clear;

    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [CELL_W-1:0]   mem_wdata;

    logic                rd_valid_q;
    logic                rd_from_mem;
    logic                rd_zero;
    logic [CELL_W-1:0]   rd_hold;
    logic [CELL_W-1:0]   rd_data;

    grid_addr #(.COLS(COLS), .ROWS(ROWS)) u_rd_addr (
        .x        (bus.vga_rd_x),
        .y        (bus.vga_rd_y),
        .addr     (rd_addr),
        .in_range (rd_in_range)
    );

    grid_addr #(.COLS(COLS), .ROWS(ROWS)) u_wr_addr (
        .x        (bus.wr_x),
        .y        (bus.wr_y),
        .addr     (wr_addr),
        .in_range (wr_in_range)
    );

    // A write that has waited STARVE_LIMIT cycles outranks the renderer
    always_comb begin
        idle     = !rst && (state == S_IDLE);
        starved  = idle && bus.wr_req && (starve_cnt == STARVE_MAX);
        serve_wr = idle && bus.wr_req && (starved || !bus.vga_rd_en);
        serve_rd = idle && bus.vga_rd_en && !starved;
        go_clear = idle && bus.clear_req && !bus.wr_req && !bus.vga_rd_en;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_cnt;
            end else if (serve_wr && wr_in_range) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = bus.wr_data;
            end else if (serve_rd && rd_in_range) begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end
        end
    end

    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.wr_ack     = serve_wr;
    assign bus.clear_busy = !rst && (state == S_CLEAR);

    // RAM data passes straight through on a served read; otherwise the held value or zero
    assign rd_data          = rd_from_mem ? bus.mem_rdata : (rd_zero ? '0 : rd_hold);
    assign bus.vga_rd_data  = rd_data;
    assign bus.vga_rd_valid = rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_from_mem <= 1'b0;
            rd_zero     <= 1'b0;
            rd_hold     <= '0;
        end else begin
            rd_valid_q  <= bus.vga_rd_en;
            rd_from_mem <= serve_rd && rd_in_range;
            rd_zero     <= bus.vga_rd_en && !starved && !(serve_rd && rd_in_range);
            rd_hold     <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= S_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (go_clear) state <= S_CLEAR;
                end
                default: state <= S_CLEAR;
            endcase

            if (!bus.wr_req || serve_wr)
                starve_cnt <= '0;
            else if (idle && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
